// File: rtl/sram_arbiter.sv
// Two-requester, burst-granted arbiter in front of a single-port synchronous SRAM.
// Optional build macro: ARB_TIMEOUT_EN enables forced handover after MAX_HOLD owned
// cycles when the other requester is waiting. Without it an owner holds indefinitely.
module sram_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned MAX_HOLD   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  output logic                  gnt0,
  output logic                  gnt1,
  input  logic                  en0,
  input  logic                  en1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e state_q, state_d;
  logic   rr_q, rr_d;          // requester favoured on a tie
  logic   gnt0_q, gnt1_q;
  logic   rvalid0_q, rvalid0_d;
  logic   rvalid1_q, rvalid1_d;
  logic   hold_max;            // owner has used up its slot

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [HoldW-1:0] hold_q, hold_d;

  assign hold_max = (hold_q == HoldW'(MAX_HOLD - 1));

  // Consecutive-owned-cycle counter: clears on any state change, saturates at MAX_HOLD-1.
  always_comb begin
    hold_d = hold_q;
    if (state_d != state_q) begin
      hold_d = '0;
    end else if (state_q != StIdle && !hold_max) begin
      hold_d = hold_q + HoldW'(1);
    end
  end

  // Hold counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  logic unused_max_hold;

  assign hold_max        = 1'b0;
  assign unused_max_hold = ^MAX_HOLD;
`endif

  // Next ownership and round-robin pointer.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    unique case (state_q)
      StIdle: begin
        if (req0 && req1) begin
          state_d = rr_q ? StOwn1 : StOwn0;
        end else if (req0) begin
          state_d = StOwn0;
        end else if (req1) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        if (!req0) begin
          state_d = req1 ? StOwn1 : StIdle;
        end else if (req1 && hold_max) begin
          state_d = StOwn1;
        end
      end
      StOwn1: begin
        if (!req1) begin
          state_d = req0 ? StOwn0 : StIdle;
        end else if (req0 && hold_max) begin
          state_d = StOwn0;
        end
      end
      default: state_d = StIdle;
    endcase
    // A grant to k hands the next tie to the other requester.
    if (state_d == StOwn0) begin
      rr_d = 1'b1;
    end else if (state_d == StOwn1) begin
      rr_d = 1'b0;
    end
  end

  // Read tags: a read issued by the owner returns on the following cycle.
  always_comb begin
    rvalid0_d = (state_q == StOwn0) && en0 && !we0;
    rvalid1_d = (state_q == StOwn1) && en1 && !we1;
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      rr_q      <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gnt0_q    <= (state_d == StOwn0);
      gnt1_q    <= (state_d == StOwn1);
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  // SRAM port mux driven only by the current owner.
  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    unique case (state_q)
      StOwn0: begin
        sram_en    = en0;
        sram_we    = we0;
        sram_addr  = addr0;
        sram_wdata = wdata0;
      end
      StOwn1: begin
        sram_en    = en1;
        sram_we    = we1;
        sram_addr  = addr1;
        sram_wdata = wdata1;
      end
      default: ;
    endcase
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata   = sram_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level ownership/memory model. Honours ARB_TIMEOUT_EN.
module tb_sram_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam bit          TbTimeout = 1'b1;
  localparam int unsigned TbMaxHold = 4;
`else
  localparam bit          TbTimeout = 1'b0;
  localparam int unsigned TbMaxHold = 32;
`endif

  logic       clk;
  logic       reset;
  logic       req0, req1, gnt0, gnt1;
  logic       en0, en1, we0, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       rvalid0, rvalid1;
  logic [7:0] rdata;
  logic       sram_en, sram_we;
  logic [3:0] sram_addr;
  logic [7:0] sram_wdata, sram_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  sram_arbiter #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .MAX_HOLD  (TbMaxHold)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .en0       (en0),
    .en1       (en1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata     (rdata),
    .sram_en   (sram_en),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM with 1-cycle read latency.
  logic [7:0] sram_mem [16];
  logic [7:0] sram_q = 8'h00;
  always @(posedge clk) begin
    if (sram_en === 1'b1) begin
      if (sram_we) sram_mem[sram_addr] <= sram_wdata;
      else         sram_q <= sram_mem[sram_addr];
    end
  end
  assign sram_rdata = sram_q;

  // Reference model: owner 0 = nobody, 1 = requester 0, 2 = requester 1.
  int         m_owner = 0;
  bit         m_rr    = 0;
  int         m_hold  = 0;
  bit         m_rv0   = 0;
  bit         m_rv1   = 0;
  logic [7:0] m_mem [16];
  logic [7:0] m_rdata = 8'h00;

  // Advance the model by one clock using the inputs currently applied, then cross the edge.
  task automatic tick();
    int nxt;
    bit r0, r1, tmo, nrv0, nrv1;
    r0 = (req0 === 1'b1);
    r1 = (req1 === 1'b1);
    if (m_owner == 1 && en0 === 1'b1) begin
      if (we0) m_mem[addr0] = wdata0; else m_rdata = m_mem[addr0];
    end
    if (m_owner == 2 && en1 === 1'b1) begin
      if (we1) m_mem[addr1] = wdata1; else m_rdata = m_mem[addr1];
    end
    nrv0 = (m_owner == 1) && en0 && !we0;
    nrv1 = (m_owner == 2) && en1 && !we1;
    tmo  = TbTimeout && (m_hold == int'(TbMaxHold) - 1);
    nxt  = m_owner;
    if (m_owner == 0) begin
      if (r0 && r1) nxt = m_rr ? 2 : 1;
      else if (r0)  nxt = 1;
      else if (r1)  nxt = 2;
    end else if (m_owner == 1) begin
      if (!r0)            nxt = r1 ? 2 : 0;
      else if (r1 && tmo) nxt = 2;
    end else begin
      if (!r1)            nxt = r0 ? 1 : 0;
      else if (r0 && tmo) nxt = 1;
    end
    if (nxt == m_owner && nxt != 0) begin
      if (m_hold < int'(TbMaxHold) - 1) m_hold++;
    end else begin
      m_hold = 0;
    end
    if (nxt == 1) m_rr = 1;
    if (nxt == 2) m_rr = 0;
    m_owner = nxt;
    m_rv0   = nrv0;
    m_rv1   = nrv1;
    if (reset === 1'b1) begin
      m_owner = 0;
      m_rr    = 0;
      m_hold  = 0;
      m_rv0   = 0;
      m_rv1   = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    en0 = 0; en1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
  endtask

  task automatic pulse_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    pulse_reset();
    #1;
    n_checks++;
    if ({gnt0, gnt1, sram_en, sram_we, rvalid0, rvalid1} !== 6'b0)
      $display("FAIL reset_state got=%b want=000000",
               {gnt0, gnt1, sram_en, sram_we, rvalid0, rvalid1});
    else n_pass++;
  endtask

  task automatic test_single();
    req0 = 1;
    tick();
    n_checks++;
    if ({gnt0, gnt1} !== 2'b10) $display("FAIL single_grant got=%b want=10", {gnt0, gnt1});
    else n_pass++;
    en0 = 1; we0 = 1; addr0 = 4'd3; wdata0 = 8'hA5;
    #1;
    n_checks++;
    if ({sram_en, sram_we, sram_addr, sram_wdata} !== {2'b11, 4'd3, 8'hA5})
      $display("FAIL single_write_mux got=%h want=%h",
               {sram_en, sram_we, sram_addr, sram_wdata}, {2'b11, 4'd3, 8'hA5});
    else n_pass++;
    tick();
    we0 = 0;
    tick();
    n_checks++;
    if (rvalid0 !== 1'b1 || rdata !== 8'hA5)
      $display("FAIL single_read got rvalid0=%b rdata=%h want 1/a5", rvalid0, rdata);
    else n_pass++;
    n_checks++;
    if (gnt1 !== 1'b0) $display("FAIL single_gnt1_low got=%b want=0", gnt1);
    else n_pass++;
    clear_inputs();
    req0 = 0;
    tick();
  endtask

  task automatic test_tie_rr();
    pulse_reset();
    req0 = 1; req1 = 1;
    tick();
    n_checks++;
    if ({gnt0, gnt1} !== 2'b10) $display("FAIL tie_first got=%b want=10", {gnt0, gnt1});
    else n_pass++;
    req0 = 0;
    tick();
    n_checks++;
    if ({gnt0, gnt1} !== 2'b01) $display("FAIL tie_handover got=%b want=01", {gnt0, gnt1});
    else n_pass++;
    req1 = 0;
    tick();
    n_checks++;
    if ({gnt0, gnt1} !== 2'b00) $display("FAIL tie_idle got=%b want=00", {gnt0, gnt1});
    else n_pass++;
    req0 = 1; req1 = 1;
    tick();
    n_checks++;
    if ({gnt0, gnt1} !== 2'b10) $display("FAIL tie_rr_again got=%b want=10", {gnt0, gnt1});
    else n_pass++;
  endtask

  task automatic test_isolation();
    req1 = 0;
    en1 = 1; we1 = 1; addr1 = 4'd5; wdata1 = 8'h3C;
    en0 = 1; we0 = 0; addr0 = 4'd7;
    #1;
    n_checks++;
    if ({sram_we, sram_addr} !== {1'b0, 4'd7})
      $display("FAIL isolate_mux got we/addr=%b/%h want 0/7", sram_we, sram_addr);
    else n_pass++;
    tick();
    addr0 = 4'd5;
    tick();
    n_checks++;
    if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== 8'h55)
      $display("FAIL isolate_word5 got rv0=%b rv1=%b rdata=%h want 1/0/55",
               rvalid0, rvalid1, rdata);
    else n_pass++;
    clear_inputs();
    req0 = 0;
    tick();
  endtask

  task automatic test_midburst_reset();
    req1 = 1;
    tick();
    n_checks++;
    if (gnt1 !== 1'b1) $display("FAIL midrst_grant got=%b want=1", gnt1);
    else n_pass++;
    en1 = 1; we1 = 0; addr1 = 4'd3;
    reset = 1;
    tick();
    n_checks++;
    if ({gnt0, gnt1, rvalid1, sram_en} !== 4'b0)
      $display("FAIL midrst_state got=%b want=0000", {gnt0, gnt1, rvalid1, sram_en});
    else n_pass++;
    reset = 0;
    clear_inputs();
    req1 = 0;
    tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int cnt;
    pulse_reset();
    req0 = 1;
    tick();
    req1 = 1;
    cnt = 0;
    while (gnt0 === 1'b1 && cnt < 20) begin
      cnt++;
      tick();
    end
    n_checks++;
    if (cnt != 4 || gnt1 !== 1'b1)
      $display("FAIL timeout_preempt got cycles=%0d gnt1=%b want 4/1", cnt, gnt1);
    else n_pass++;
    req1 = 0;
    tick();
    n_checks++;
    if ({gnt0, gnt1} !== 2'b10) $display("FAIL timeout_return got=%b want=10", {gnt0, gnt1});
    else n_pass++;
    for (int i = 0; i < 10; i++) tick();
    req1 = 1;
    tick();
    n_checks++;
    if ({gnt0, gnt1} !== 2'b01) $display("FAIL timeout_saturate got=%b want=01", {gnt0, gnt1});
    else n_pass++;
    req0 = 0; req1 = 0;
    tick();
  endtask
`else
  task automatic test_hold_forever();
    pulse_reset();
    req0 = 1;
    tick();
    req1 = 1;
    for (int i = 0; i < 40; i++) tick();
    n_checks++;
    if ({gnt0, gnt1} !== 2'b10) $display("FAIL hold_forever got=%b want=10", {gnt0, gnt1});
    else n_pass++;
    req0 = 0;
    tick();
    n_checks++;
    if ({gnt0, gnt1} !== 2'b01) $display("FAIL hold_release got=%b want=01", {gnt0, gnt1});
    else n_pass++;
    req1 = 0;
    tick();
  endtask
`endif

  task automatic test_random();
    logic       exp_en, exp_we;
    logic [3:0] exp_addr;
    logic [7:0] exp_wd;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(7) == 0) req0 = ~req0;
      if ($urandom_range(7) == 0) req1 = ~req1;
      en0 = 1'($urandom_range(1));   we0 = 1'($urandom_range(1));
      en1 = 1'($urandom_range(1));   we1 = 1'($urandom_range(1));
      addr0 = 4'($urandom_range(15)); addr1 = 4'($urandom_range(15));
      wdata0 = 8'($urandom);          wdata1 = 8'($urandom);
      reset = ($urandom_range(63) == 0);
      #1;
      exp_en = 0; exp_we = 0; exp_addr = 0; exp_wd = 0;
      if (m_owner == 1) begin
        exp_en = en0; exp_we = we0; exp_addr = addr0; exp_wd = wdata0;
      end else if (m_owner == 2) begin
        exp_en = en1; exp_we = we1; exp_addr = addr1; exp_wd = wdata1;
      end
      n_checks++;
      if ({gnt0, gnt1, rvalid0, rvalid1, sram_en, sram_we} !==
          {m_owner == 1, m_owner == 2, m_rv0, m_rv1, exp_en, exp_we})
        $display("FAIL rand_ctrl cyc=%0d got=%b want=%b", cyc,
                 {gnt0, gnt1, rvalid0, rvalid1, sram_en, sram_we},
                 {m_owner == 1, m_owner == 2, m_rv0, m_rv1, exp_en, exp_we});
      else n_pass++;
      n_checks++;
      if ({sram_addr, sram_wdata} !== {exp_addr, exp_wd})
        $display("FAIL rand_bus cyc=%0d got=%h want=%h", cyc,
                 {sram_addr, sram_wdata}, {exp_addr, exp_wd});
      else n_pass++;
      if (m_rv0 || m_rv1) begin
        n_checks++;
        if (rdata !== m_rdata)
          $display("FAIL rand_rdata cyc=%0d got=%h want=%h", cyc, rdata, m_rdata);
        else n_pass++;
      end
      tick();
    end
    reset = 0;
    req0 = 0; req1 = 0;
    clear_inputs();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      sram_mem[i] = 8'(i * 8'h11);
      m_mem[i]    = 8'(i * 8'h11);
    end
    clk = 0;
    reset = 1;
    req0 = 0; req1 = 0;
    clear_inputs();
    test_reset();
    test_single();
    test_tie_rr();
    test_isolation();
    test_midburst_reset();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_hold_forever();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
